cla_add_sched: RTL
==================

# cla_add_sched

Two-requester scheduler that shares one W-bit carry-lookahead adder between clients and sequences multi-word add/subtract transactions through it. The adder is built from the team's 4-bit lookahead units plus one second-level unit. The block sits between the integer/crypto front-ends and the adder, and provides the following:
- round-robin arbitration at transaction granularity;
- carry chaining across words;
- a registered, backpressurable result port.

## Interface
- W, 16, word width; multiple of 4, 4 ≤ W ≤ 16 (at most 4 groups into one second-level unit).
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  2  per-requester word valid; bit r belongs to requester r.
- req_ready  out  2  per-requester word accepted this cycle.
- req_a  in  2W  operand A; requester r occupies bits [r*W +: W].
- req_b  in  2W  operand B, same packing as req_a.
- req_sub  in  2  subtract (A−B) when 1; sampled on the first word only.
- req_last  in  2  marks the final (most significant) word of a transaction.
- rsp_valid  out  1  result word valid.
- rsp_ready  in  1  consumer accepts the result word.
- rsp_sum  out  W  result word.
- rsp_cout  out  1  carry out of this word.
- rsp_id  out  1  requester that owns the word.
- rsp_last  out  1  copy of req_last for this word.
- rsp_ovf  out  1  signed overflow; meaningful only when rsp_last=1.

## Operation
- Words are presented least significant first. A transaction is every word from the first accepted word through the word carrying last.
- FSM states:
  - IDLE: req_ready=0.
    - One requester valid: grant it, go to BUSY.
    - Both valid: grant the one selected by the round-robin pointer rr, go to BUSY.
  - BUSY(g): req_ready[g] = !rsp_valid || rsp_ready. The other bit of req_ready is 0.
    - Accepting a word with req_last=1 returns the FSM to IDLE.
    - On that return, rr points to the requester that was not g.
- Carry in for each word:
  - First word of a transaction: cin = sub_q, where sub_q is captured from req_sub[g] on that word.
  - Later words: cin = the carry out registered from the previous word.
  - req_sub on later words is ignored.
- Adder operands are A and (sub_q ? ~B : B), fed through the W/4-group lookahead tree.
- Registered results on each accepted word:
  - rsp_sum = the adder sum.
  - rsp_cout = the group carry out. For subtract, rsp_cout=1 means no borrow.
  - rsp_id = g.
  - rsp_last = req_last[g].
  - rsp_valid is set to 1.
- When rsp_valid && rsp_ready and no new word is accepted in the same cycle, rsp_valid clears.
- Output register is one entry deep; a new word may be accepted in the same cycle the old result drains.
- No combinational path exists from req_valid or req_a/req_b to req_ready or to any rsp_* output.
- rst mid-transaction aborts it:
  - returns to IDLE;
  - discards any pending result;
  - clears the carry.
  - The next transaction starts fresh.

## Timing
- Reset values:
  - state IDLE, rr=0 (requester 0 wins the first tie);
  - carry=0, sub_q=0;
  - req_ready=00, rsp_valid=0;
  - rsp_sum, rsp_cout, rsp_id, rsp_last, rsp_ovf all 0.
- Grant costs 1 cycle: req_valid first seen in IDLE at cycle n gives req_ready at n+1 and rsp_valid at n+2.
- BUSY throughput: 1 word/cycle while rsp_ready=1.
- One idle bubble follows every transaction, because arbitration happens only in IDLE.
- rsp_* outputs are stable while rsp_valid=1 && rsp_ready=0.
- A requester must hold req_valid and its data until req_ready; dropping req_valid in BUSY merely stalls.

## Configuration
- CLA_SCHED_OVF_EN defined:
  - rsp_ovf = carry into MSB XOR carry out of MSB for the word with last=1;
  - rsp_ovf = 0 on all other words.
- Not defined: the rsp_ovf port still exists, is tied to 0, and its logic is removed.

## Test plan
All values are for W=16.
- **Single add:** r0 sends a=0x1234, b=0x0001, sub=0, last=1 at cycle 0.
  - Expect req_ready[0]=1 at cycle 1.
  - Expect at cycle 2: rsp_valid=1, rsp_sum=0x1235, rsp_cout=0, rsp_id=0, rsp_last=1.
- **Carry chain:** r1 sends two words with sub=0: (0xFFFF, 0x0001) then (0x0000, 0x0000, last=1).
  - Expect rsp_sum=0x0000 with rsp_cout=1.
  - Then rsp_sum=0x0001 with rsp_cout=0 and rsp_last=1.
- **Subtract:** r0 sends sub=1, a=0x0005, b=0x0007, last=1.
  - Expect rsp_sum=0xFFFE, rsp_cout=0, rsp_ovf=0.
  - Then sub=1, a=0x8000, b=0x0001: expect rsp_sum=0x7FFF, rsp_cout=1, rsp_ovf=1 (0 when CLA_SCHED_OVF_EN is not defined).
- **Arbitration:** both requesters hold one-word transactions valid from reset.
  - Expect service order r0, r1, r0, r1.
  - Expect exactly one idle cycle between transactions, and req_ready never 11.
- **Backpressure:** hold rsp_ready=0 for 3 cycles during the second word of a 3-word transaction.
  - Expect req_ready=00 during the stall, rsp_* frozen.
  - Expect all 3 words delivered once, in order, with the correct carries.
- **Reset mid-transaction:** pulse rst after the first word of a 2-word r0 (0xFFFF+0x0001) transaction.
  - Expect rsp_valid=0 and req_ready=00 the next cycle.
  - Expect a new single-word 0x0001+0x0001 to produce 0x0002, i.e. no stale carry.

Source files
------------

// File: rtl/cla_add_sched.sv
// Two-requester scheduler sharing one W-bit carry-lookahead adder for multi-word add/subtract.
// Optional macro CLA_SCHED_OVF_EN enables the signed-overflow flag on rsp_ovf.
module cla_add_sched #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_sub,
  input  logic [1:0]     req_last,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic           rsp_id,
  output logic           rsp_last,
  output logic           rsp_ovf
);

  // state | meaning
  // IDLE  | no grant; arbitrate between requesters using rr
  // BUSY  | requester gnt owns the adder until its last word is accepted

  localparam int NG = W / 4;

  // Flattened lookahead carry into position n of a 4-wide generate/propagate slice.
  function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                    input logic c0, input int n);
    logic c;
    logic t;
    c = c0;
    for (int k = 0; k < 4; k++) if (k < n) c = c & p[k];
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        t = g[j];
        for (int k = 0; k < 4; k++) if (k > j && k < n) t = t & p[k];
        c = c | t;
      end
    end
    return c;
  endfunction

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  logic         gnt, rr, carry, sub_q, first;
  logic [W-1:0] op_a, b_sel, op_b, bg, bp, bc, sum;
  logic [3:0]   gg, gp;
  logic [4:0]   gc;
  logic         sub_eff, cin, cout, can_take, accept;

  always_comb begin
    op_a    = gnt ? req_a[2*W-1:W] : req_a[W-1:0];
    b_sel   = gnt ? req_b[2*W-1:W] : req_b[W-1:0];
    sub_eff = first ? req_sub[gnt] : sub_q;
    cin     = first ? req_sub[gnt] : carry;
    op_b    = sub_eff ? ~b_sel : b_sel;
    bg      = op_a & op_b;
    bp      = op_a ^ op_b;
    gg      = '0;
    gp      = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = la_carry(bg[4*k +: 4], bp[4*k +: 4], 1'b0, 4);
      gp[k] = &bp[4*k +: 4];
    end
    // second-level unit: carries into each group from group generate/propagate
    for (int k = 0; k <= 4; k++) gc[k] = la_carry(gg, gp, cin, k);
    bc = '0;
    for (int k = 0; k < NG; k++)
      for (int i = 0; i < 4; i++)
        bc[4*k+i] = la_carry(bg[4*k +: 4], bp[4*k +: 4], gc[k], i);
    sum  = bp ^ bc;
    cout = gc[NG];
  end

  assign can_take  = (state == BUSY) && (!rsp_valid || rsp_ready);
  assign req_ready = can_take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = can_take && req_valid[gnt];

`ifdef CLA_SCHED_OVF_EN
  logic ovf_d;
  assign ovf_d = req_last[gnt] & (bc[W-1] ^ cout);
`else
  assign rsp_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr        <= 1'b0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      first     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
`ifdef CLA_SCHED_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt   <= (&req_valid) ? rr : req_valid[1];
            first <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum;
            rsp_cout  <= cout;
            rsp_id    <= gnt;
            rsp_last  <= req_last[gnt];
`ifdef CLA_SCHED_OVF_EN
            rsp_ovf   <= ovf_d;
`endif
            carry     <= cout;
            sub_q     <= sub_eff;
            first     <= 1'b0;
            if (req_last[gnt]) begin
              state <= IDLE;
              rr    <= ~gnt;
              carry <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
